// File: rtl/dmem_if.sv
// dmem_if: request/response bus between the MEM pipeline stage (master) and
// the data-memory responder (slave).
//
// Handshake rules: a transfer happens on a rising edge where valid and ready
// are both high. The request channel is req_valid/req_ready, and the response
// channel is resp_valid/resp_ready. Once the responder raises resp_valid,
// read_data and resp_err stay stable until the response handshake completes.
// busy mirrors "responder not idle" and acts as a pipeline stall.
//
// Signals:
//   req_valid, req_ready          request handshake
//   address[10:0]                 byte address; word = address[10:2]
//   MemRead[3:0], MemWrite[3:0]   byte-lane read / write enables
//   write_data[31:0]              store data, lane k = bits [8k+7:8k]
//   resp_valid, resp_ready        response handshake
//   read_data[31:0], resp_err     response payload
//   busy                          stall indication
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic [10:0] address;
  logic [3:0]  MemRead;
  logic [3:0]  MemWrite;
  logic [31:0] write_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] read_data;
  logic        resp_err;
  logic        busy;

  modport master (
    output req_valid, address, MemRead, MemWrite, write_data, resp_ready,
    input  req_ready, resp_valid, read_data, resp_err, busy
  );

  modport slave (
    input  req_valid, address, MemRead, MemWrite, write_data, resp_ready,
    output req_ready, resp_valid, read_data, resp_err, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: byte-lane data memory with a fixed access latency.
//
// A request is accepted in IDLE. The responder waits LATENCY edges and then
// performs the access. It holds the response in RESP until the consumer takes
// it. Only one request can be outstanding at a time.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous reset, ACTIVE-HIGH despite the name
//   bus        dmem_if.slave request/response bus
//   state_dbg  current FSM state (0 = IDLE, 1 = WAIT, 2 = RESP)
//
// Parameters:
//   LATENCY      edges from acceptance to resp_valid (1..15)
//   DEPTH_WORDS  number of 32-bit words; word index wraps modulo this value
module dmem_responder #(
  parameter int LATENCY     = 2,
  parameter int DEPTH_WORDS = 512
) (
  input  logic       clk,
  input  logic       reset_n,
  dmem_if.slave      bus,
  output logic [1:0] state_dbg
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic [AW-1:0] idx_q;
  logic [3:0]    rd_lanes_q;
  logic [3:0]    wr_lanes_q;
  logic [31:0]   wdata_q;

  // Deliberately no reset: contents survive reset.
  logic [31:0]   mem [DEPTH_WORDS];

  logic [AW-1:0] req_idx;
  logic          accept;
  logic          is_rd;
  logic          is_wr;
  logic          access;
  logic          do_write;
  logic [31:0]   stored;
  logic [31:0]   rd_data;

  // The modulo wraps out-of-range word indices for any DEPTH_WORDS.
  // For a power of two it reduces to plain truncation.
  assign req_idx  = AW'({23'd0, bus.address[10:2]} % 32'($unsigned(DEPTH_WORDS)));
  assign accept   = (state == IDLE) && bus.req_valid && bus.req_ready;
  assign is_rd    = |rd_lanes_q;
  assign is_wr    = |wr_lanes_q;
  // The access happens on the edge that leaves WAIT. An async reset forces
  // IDLE, so a discarded request can never reach this point.
  assign access   = (state == WAIT) && (cnt == 4'd0);
  assign do_write = access && is_wr && !is_rd;
  assign stored   = mem[idx_q];
  assign state_dbg = state;

  // Unselected read lanes return zero, with no sign extension.
  always_comb begin
    rd_data = 32'd0;
    for (int k = 0; k < 4; k++) begin
      if (rd_lanes_q[k]) rd_data[8*k +: 8] = stored[8*k +: 8];
    end
  end

  // Request capture. There is no reset here because these registers are
  // only consumed after an accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q      <= req_idx;
      rd_lanes_q <= bus.MemRead;
      wr_lanes_q <= bus.MemWrite;
      wdata_q    <= bus.write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_lanes_q[k]) mem[idx_q][8*k +: 8] <= wdata_q[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      bus.req_ready  <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.read_data  <= 32'd0;
      bus.busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state         <= WAIT;
            cnt           <= 4'(LATENCY - 1);
            bus.req_ready <= 1'b0;
            bus.busy      <= 1'b1;
          end else begin
            bus.req_ready <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= is_rd && is_wr;
            bus.read_data  <= (is_rd && !is_wr) ? rd_data : 32'd0;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            state          <= IDLE;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.read_data  <= 32'd0;
            bus.req_ready  <= 1'b1;
            bus.busy       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: bench for dmem_responder.
// dut_a is the default configuration (LATENCY 2, 512 words).
// dut_b uses LATENCY 1 with 256 words, which exercises word-index wrap.
// The shared stimulus variables are steered to one DUT at a time by sel.
module tb_dmem_responder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // ---------------- DUTs and steering ----------------
  dmem_if a_if ();
  dmem_if b_if ();
  logic [1:0] a_state, b_state;

  dmem_responder #(.LATENCY(2), .DEPTH_WORDS(512)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(a_if.slave), .state_dbg(a_state));
  dmem_responder #(.LATENCY(1), .DEPTH_WORDS(256)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(b_if.slave), .state_dbg(b_state));

  logic        sel;
  logic        req_valid, resp_ready;
  logic [10:0] address;
  logic [3:0]  mem_read, mem_write;
  logic [31:0] write_data;

  assign a_if.req_valid  = req_valid & ~sel;
  assign b_if.req_valid  = req_valid & sel;
  assign a_if.resp_ready = resp_ready & ~sel;
  assign b_if.resp_ready = resp_ready & sel;
  assign a_if.address    = address;
  assign b_if.address    = address;
  assign a_if.MemRead    = mem_read;
  assign b_if.MemRead    = mem_read;
  assign a_if.MemWrite   = mem_write;
  assign b_if.MemWrite   = mem_write;
  assign a_if.write_data = write_data;
  assign b_if.write_data = write_data;

  wire        o_req_ready  = sel ? b_if.req_ready  : a_if.req_ready;
  wire        o_resp_valid = sel ? b_if.resp_valid : a_if.resp_valid;
  wire [31:0] o_read_data  = sel ? b_if.read_data  : a_if.read_data;
  wire        o_resp_err   = sel ? b_if.resp_err   : a_if.resp_err;
  wire        o_busy       = sel ? b_if.busy       : a_if.busy;
  wire [1:0]  o_state      = sel ? b_state         : a_state;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic        exp_err_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},  32'(o_req_ready),  32'd0);
    check({tag, "_resp_valid"}, 32'(o_resp_valid), 32'd0);
    check({tag, "_resp_err"},   32'(o_resp_err),   32'd0);
    check({tag, "_read_data"},  o_read_data,       32'd0);
    check({tag, "_busy"},       32'(o_busy),       32'd0);
    check({tag, "_state"},      32'(o_state),      32'd0);
  endtask

  // Reference model of dut_a memory, keyed by word index.
  logic [31:0] model [int];

  task automatic model_apply(input logic [10:0] a, input logic [3:0] mr, input logic [3:0] mw,
                             input logic [31:0] wd, output logic [31:0] ed, output logic ee);
    int w;
    logic [31:0] cur;
    w  = int'(a[10:2]);
    ed = 32'd0;
    ee = 1'b0;
    cur = model.exists(w) ? model[w] : 32'd0;
    if (mr != 4'd0 && mw != 4'd0) begin
      ee = 1'b1;
    end else if (mr != 4'd0) begin
      for (int k = 0; k < 4; k++) if (mr[k]) ed[8*k +: 8] = cur[8*k +: 8];
    end else if (mw != 4'd0) begin
      for (int k = 0; k < 4; k++) if (mw[k]) cur[8*k +: 8] = wd[8*k +: 8];
      model[w] = cur;
    end
  endtask

  // ---------------- driver ----------------
  // Call at posedge+#1 with the selected DUT idle. A full transaction checks
  // acceptance, exact response latency, the held response under
  // backpressure, and the return to IDLE. During backpressure a competing
  // request is driven and must be ignored.
  task automatic xact(input logic s, input logic [10:0] a, input logic [3:0] mr,
                      input logic [3:0] mw, input logic [31:0] wd,
                      input logic [31:0] ed, input logic ee, input int hold);
    int lat;
    logic [31:0] e_d;
    logic        e_e;
    lat = s ? 1 : 2;
    sel = s;
    #0;
    check("idle_req_ready", 32'(o_req_ready), 32'd1);
    req_valid = 1'b1; address = a; mem_read = mr; mem_write = mw; write_data = wd;
    exp_q.push_back(ed);
    exp_err_q.push_back(ee);
    @(posedge clk); #1;
    req_valid = 1'b0;
    address = 11'($urandom); mem_read = 4'($urandom); mem_write = 4'($urandom);
    write_data = $urandom;
    check("accept_busy", 32'(o_busy), 32'd1);
    check("accept_req_ready", 32'(o_req_ready), 32'd0);
    check("resp_early", 32'(o_resp_valid), 32'd0);
    repeat (lat - 1) begin
      @(posedge clk); #1;
      check("resp_early", 32'(o_resp_valid), 32'd0);
    end
    @(posedge clk); #1;
    check("resp_on_time", 32'(o_resp_valid), 32'd1);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; address = 11'h010; mem_read = 4'h0; mem_write = 4'hF;
      write_data = 32'hBAD0BAD0;
      @(posedge clk); #1;
      check("hold_resp_valid", 32'(o_resp_valid), 32'd1);
      check("hold_read_data", o_read_data, exp_q[0]);
      check("hold_req_ready", 32'(o_req_ready), 32'd0);
      check("hold_busy", 32'(o_busy), 32'd1);
    end
    resp_ready = 1'b1;
    e_d = exp_q.pop_front();
    e_e = exp_err_q.pop_front();
    check("read_data", o_read_data, e_d);
    check("resp_err", 32'(o_resp_err), 32'(e_e));
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("done_resp_valid", 32'(o_resp_valid), 32'd0);
    check("done_req_ready", 32'(o_req_ready), 32'd1);
    check("done_busy", 32'(o_busy), 32'd0);
    check("done_state_idle", 32'(o_state), 32'd0);
    req_valid = 1'b0;
  endtask

  // Transaction on dut_a whose expected response comes from the model.
  task automatic xact_m(input logic [10:0] a, input logic [3:0] mr, input logic [3:0] mw,
                        input logic [31:0] wd, input int hold);
    logic [31:0] ed;
    logic        ee;
    model_apply(a, mr, mw, wd, ed, ee);
    xact(1'b0, a, mr, mw, wd, ed, ee, hold);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic        s;
    logic [10:0] a;
    logic [3:0]  mr;
    logic [3:0]  mw;
    logic [31:0] wd;
    logic [31:0] ed;
    logic        ee;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [31:0] dd;
    logic        de;
    logic [10:0] addrs[4];

    tbl.push_back('{1'b0, 11'h010, 4'h0, 4'hF, 32'hDEADBEEF, 32'h00000000, 1'b0});
    tbl.push_back('{1'b0, 11'h010, 4'hF, 4'h0, 32'h0,        32'hDEADBEEF, 1'b0});
    tbl.push_back('{1'b0, 11'h010, 4'h0, 4'h5, 32'h11223344, 32'h00000000, 1'b0});
    tbl.push_back('{1'b0, 11'h010, 4'hF, 4'h0, 32'h0,        32'hDE22BE44, 1'b0});
    tbl.push_back('{1'b0, 11'h010, 4'h2, 4'h0, 32'h0,        32'h0000BE00, 1'b0});
    tbl.push_back('{1'b0, 11'h010, 4'hF, 4'hF, 32'hFFFFFFFF, 32'h00000000, 1'b1});
    tbl.push_back('{1'b0, 11'h013, 4'hF, 4'h0, 32'h0,        32'hDE22BE44, 1'b0});
    tbl.push_back('{1'b0, 11'h010, 4'h0, 4'h0, 32'h55555555, 32'h00000000, 1'b0});
    tbl.push_back('{1'b0, 11'h010, 4'hF, 4'h0, 32'h0,        32'hDE22BE44, 1'b0});
    tbl.push_back('{1'b0, 11'h020, 4'h0, 4'hF, 32'h12345678, 32'h00000000, 1'b0});
    tbl.push_back('{1'b0, 11'h7FC, 4'h0, 4'hF, 32'hA5A5A5A5, 32'h00000000, 1'b0});
    // 0x7FC + 4 truncated to 11 bits lands on word 0
    tbl.push_back('{1'b0, 11'h000, 4'h0, 4'hF, 32'h0BADF00D, 32'h00000000, 1'b0});
    tbl.push_back('{1'b0, 11'h7FC, 4'hF, 4'h0, 32'h0,        32'hA5A5A5A5, 1'b0});
    tbl.push_back('{1'b0, 11'h000, 4'h9, 4'h0, 32'h0,        32'h0B00000D, 1'b0});
    // dut_b: 256 words, so word 256 wraps to 0 and word 511 wraps to 255
    tbl.push_back('{1'b1, 11'h400, 4'h0, 4'hF, 32'h11112222, 32'h00000000, 1'b0});
    tbl.push_back('{1'b1, 11'h000, 4'hF, 4'h0, 32'h0,        32'h11112222, 1'b0});
    tbl.push_back('{1'b1, 11'h7FC, 4'h0, 4'hF, 32'h33334444, 32'h00000000, 1'b0});
    tbl.push_back('{1'b1, 11'h3FC, 4'hF, 4'h0, 32'h0,        32'h33334444, 1'b0});
    tbl.push_back('{1'b1, 11'h000, 4'h4, 4'h0, 32'h0,        32'h00110000, 1'b0});

    sel = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    address = '0; mem_read = '0; mem_write = '0; write_data = '0;

    // Reset state.
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst_a");
    sel = 1'b1; #0;
    check_reset_outputs("rst_b");
    sel = 1'b0;
    reset_n = 1'b0;
    #0;
    check("deassert_req_ready", 32'(o_req_ready), 32'd0);
    @(posedge clk); #1;
    check("first_edge_req_ready", 32'(o_req_ready), 32'd1);

    // Table-driven vectors.
    foreach (tbl[i]) begin
      if (!tbl[i].s) model_apply(tbl[i].a, tbl[i].mr, tbl[i].mw, tbl[i].wd, dd, de);
      xact(tbl[i].s, tbl[i].a, tbl[i].mr, tbl[i].mw, tbl[i].wd, tbl[i].ed, tbl[i].ee, 0);
    end

    // Backpressure: hold 5 cycles while a competing write is offered.
    xact_m(11'h010, 4'hF, 4'h0, 32'h0, 5);
    xact_m(11'h010, 4'hF, 4'h0, 32'h0, 0);

    // Reset in WAIT: the write of 0xCAFEF00D must never reach memory.
    sel = 1'b0;
    req_valid = 1'b1; address = 11'h020; mem_read = 4'h0; mem_write = 4'hF;
    write_data = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("wait_state", 32'(o_state), 32'd1);
    reset_n = 1'b1;
    #1;
    check_reset_outputs("rst_wait");
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst_wait_hold");
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("rst_wait_ready", 32'(o_req_ready), 32'd1);
    xact_m(11'h020, 4'hF, 4'h0, 32'h0, 0);

    // Reset in RESP: the write has already happened, and the response is dropped.
    model_apply(11'h020, 4'h0, 4'h1, 32'h000000FF, dd, de);
    req_valid = 1'b1; address = 11'h020; mem_read = 4'h0; mem_write = 4'h1;
    write_data = 32'h000000FF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("resp_state", 32'(o_state), 32'd2);
    reset_n = 1'b1;
    #1;
    check_reset_outputs("rst_resp");
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("rst_resp_ready", 32'(o_req_ready), 32'd1);
    xact_m(11'h020, 4'hF, 4'h0, 32'h0, 0);

    // Random mix over initialised words, checked against the model.
    addrs[0] = 11'h010; addrs[1] = 11'h020; addrs[2] = 11'h7FC; addrs[3] = 11'h000;
    for (int i = 0; i < 12; i++) begin
      logic [10:0] ra;
      int op;
      ra = addrs[$urandom_range(0, 3)] | 11'($urandom_range(0, 3));
      op = $urandom_range(0, 2);
      if (op == 0)      xact_m(ra, 4'($urandom_range(1, 15)), 4'h0, $urandom, $urandom_range(0, 2));
      else if (op == 1) xact_m(ra, 4'h0, 4'($urandom_range(1, 15)), $urandom, $urandom_range(0, 2));
      else              xact_m(ra, 4'($urandom), 4'($urandom), $urandom, $urandom_range(0, 2));
    end

    // dut_b memory must have survived the resets.
    xact(1'b1, 11'h000, 4'hF, 4'h0, 32'h0, 32'h11112222, 1'b0, 1);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
